bcd_serial_add_ctrl: RTL and testbench

Sequencing controller that performs multi-digit packed-BCD addition and subtraction by time-sharing a single one-digit BCD adder stage, least-significant digit first, one digit per clock. It latches operands on a start handshake, steps a digit counter, carries the decimal carry between digits in a register, and assembles the packed result. It sits between a register file or keypad/display front end and the one-digit BCD adder datapath. It replaces a wide parallel BCD adder chain where area matters more than latency.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_serial_add_ctrl.sv | 113 +++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial packed-BCD add/subtract controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    function automatic logic [BCD_DIGIT_W-1:0] nines_comp(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return BCD_DIGIT_W'(BCD_MAX) - d;
    endfunction

    function automatic logic digit_valid(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return d <= BCD_DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary add, then +6 correction when the raw sum passes 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   co
);

    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
        s   = raw[BCD_DIGIT_W-1:0];
        co  = 1'b0;
        if (raw > (BCD_DIGIT_W+1)'(BCD_MAX)) begin
            s  = raw[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(6);
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD add/subtract, one digit per clock through a
// single shared digit adder, least-significant digit first.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int IW = $clog2(DIGITS);

    bcd_state_t state_q, state_d;

    logic [4*DIGITS-1:0] a_q, b_q, b_in, sum_q;
    logic [IW-1:0]       idx;
    logic                carry, cout_q, inv_q;
    logic                ops_ok, last;
    logic [3:0]          ds;
    logic                dco;

    // Subtraction is a + nines(b) + 1, so b is complemented on the way in.
    always_comb begin
        ops_ok = 1'b1;
        b_in   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!digit_valid(a[4*k +: 4]) || !digit_valid(b[4*k +: 4]))
                ops_ok = 1'b0;
            b_in[4*k +: 4] = sub ? nines_comp(b[4*k +: 4]) : b[4*k +: 4];
        end
    end

    assign last = (idx == IW'(DIGITS-1));

    bcd_digit_add u_dig (
        .a  (a_q[4*idx +: 4]),
        .b  (b_q[4*idx +: 4]),
        .ci (carry),
        .s  (ds),
        .co (dco)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ops_ok ? RUN : DONE;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sum_q <= '0;
                        if (ops_ok) begin
                            a_q   <= a;
                            b_q   <= b_in;
                            idx   <= '0;
                            carry <= sub | cin;
                            inv_q <= 1'b0;
                        end else begin
                            cout_q <= 1'b0;
                            inv_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    sum_q[4*idx +: 4] <= ds;
                    carry <= dco;
                    idx   <= idx + 1'b1;
                    if (last) cout_q <= dco;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl (DIGITS=4): directed and random operations
// checked against an integer-arithmetic decimal model.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, sub, cin;
    logic [15:0]   a, b;
    logic          busy, done, cout, invalid;
    logic [15:0]   sum;

    int n_pass = 0;
    int n_total = 0;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
        .cout(cout), .invalid(invalid)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic void model(input logic [15:0] ma, mb, input logic ms, mc,
                                  output logic [15:0] es, output logic ec, ei);
        int ia, ib, r;
        bit ok;
        ok = 1;
        for (int k = 0; k < D; k++)
            if (ma[4*k +: 4] > 9 || mb[4*k +: 4] > 9) ok = 0;
        if (!ok) begin
            es = '0; ec = 1'b0; ei = 1'b1;
            return;
        end
        ia = bcd2int(ma);
        ib = bcd2int(mb);
        if (ms) begin
            r  = ia - ib + 10000;
            ec = (ia >= ib);
        end else begin
            r  = ia + ib + int'(mc);
            ec = (r >= 10000);
        end
        es = int2bcd(r % 10000);
        ei = 1'b0;
    endfunction

    function automatic logic [15:0] rnd_bcd(input bit allow_bad);
        logic [15:0] r;
        for (int k = 0; k < D; k++)
            r[4*k +: 4] = 4'((allow_bad && $urandom_range(0, 7) == 0)
                             ? $urandom_range(10, 15) : $urandom_range(0, 9));
        return r;
    endfunction

    // Driver: called one step after a rising edge with the DUT idle.
    task automatic run_op(input logic [15:0] ta, tb, input logic ts, tc,
                          input string nm);
        logic [15:0] es;
        logic ec, ei;
        int n;
        model(ta, tb, ts, tc, es, ec, ei);
        a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = rnd_bcd(1'b1); b = rnd_bcd(1'b1); sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start got %b want 1", nm, busy);
        else n_pass++;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            n_total++;
            if (busy !== 1'b1) $display("FAIL %s busy_during_run got %b want 1", nm, busy);
            else n_pass++;
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (n !== (ei ? 0 : D)) $display("FAIL %s latency got %0d want %0d", nm, n, ei ? 0 : D);
        else n_pass++;
        n_total++;
        if (sum !== es || cout !== ec || invalid !== ei)
            $display("FAIL %s result got sum=%h cout=%b inv=%b want sum=%h cout=%b inv=%b",
                     nm, sum, cout, invalid, es, ec, ei);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== es || cout !== ec || invalid !== ei)
            $display("FAIL %s after_done got busy=%b done=%b sum=%h want busy=0 done=0 sum=%h",
                     nm, busy, done, sum, es);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; sub = 1'b0; cin = 1'b0;
        a = 16'h1234; b = 16'h5678;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_total++;
            if ({busy, done, sum, cout, invalid} !== '0)
                $display("FAIL reset got busy=%b done=%b sum=%h cout=%b inv=%b want all 0",
                         busy, done, sum, cout, invalid);
            else n_pass++;
        end
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_release busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_add();
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, "add_1234_5678");
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, "add_9999_0001");
        run_op(16'h9999, 16'h9999, 1'b0, 1'b1, "add_9999_9999_c");
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, "add_zero_cin");
    endtask

    task automatic test_sub();
        run_op(16'h0042, 16'h0017, 1'b1, 1'b0, "sub_42_17");
        run_op(16'h0017, 16'h0042, 1'b1, 1'b1, "sub_17_42");
        run_op(16'h5000, 16'h5000, 1'b1, 1'b0, "sub_equal");
    endtask

    task automatic test_invalid();
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, "invalid_a");
        run_op(16'h0001, 16'hF000, 1'b1, 1'b0, "invalid_b");
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, "valid_after_invalid");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            run_op(rnd_bcd(1'b1), rnd_bcd(1'b1), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), "random");
    endtask

    task automatic test_collision();
        int n;
        a = 16'h0123; b = 16'h0456; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 2;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (n !== D || sum !== 16'h0579 || cout !== 1'b0)
            $display("FAIL collision_run got n=%0d sum=%h cout=%b want n=%0d sum=0579 cout=0",
                     n, sum, cout, D);
        else n_pass++;
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (busy !== 1'b0 || sum !== 16'h0579)
                $display("FAIL collision_done got busy=%b sum=%h want busy=0 sum=0579", busy, sum);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int t, first, cnt;
        a = 16'h0250; b = 16'h0750; sub = 1'b0; cin = 1'b0; start = 1'b1;
        first = -1; cnt = 0;
        for (t = 0; t < 16; t++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                cnt++;
                n_total++;
                if (sum !== 16'h1000 || cout !== 1'b0)
                    $display("FAIL b2b_result got sum=%h cout=%b want 1000 0", sum, cout);
                else n_pass++;
                if (first < 0) first = t;
                else begin
                    n_total++;
                    if (t - first !== D + 2)
                        $display("FAIL b2b_spacing got %0d want %0d", t - first, D + 2);
                    else n_pass++;
                    first = t;
                end
            end
        end
        start = 1'b0;
        n_total++;
        if (cnt < 2) $display("FAIL b2b_count got %0d want >=2", cnt);
        else n_pass++;
        for (int i = 0; i < 12 && busy === 1'b1; i++) begin
            @(posedge clk); #1;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL b2b_drain busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({busy, done, sum, cout, invalid} !== '0)
            $display("FAIL reset_mid_run got busy=%b done=%b sum=%h cout=%b inv=%b want all 0",
                     busy, done, sum, cout, invalid);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid_run_idle got busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0, "after_reset_5_5");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_invalid();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
